// File: rtl/weave_pkg.sv
// weave_pkg: shared types for the weave row transmitter and any matching
// receiver-side checker.
//   mode_e  - row pattern select (plain / twill / satin / user)
//   state_e - transmitter FSM states
//   rotl8   - 8-bit rotate-left helper used by the row generator
package weave_pkg;

  typedef enum logic [1:0] {
    MODE_PLAIN = 2'b00,
    MODE_TWILL = 2'b01,
    MODE_SATIN = 2'b10,
    MODE_USER  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    FINISH = 2'b10
  } state_e;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] w;
    w = {v, v} << s;
    return w[15:8];
  endfunction

endpackage

// File: rtl/weave_row_gen.sv
// weave_row_gen: combinational row-byte generator.
//   mode_i - pattern select
//   base_i - seed row byte
//   r_i    - row index within the burst
//   row_o  - row byte (1 = warp up)
module weave_row_gen
  import weave_pkg::*;
#(
  parameter int unsigned SATIN_STEP = 3
) (
  input  mode_e       mode_i,
  input  logic [7:0]  base_i,
  input  logic [7:0]  r_i,
  output logic [7:0]  row_o
);

  localparam logic [2:0] STEP3 = 3'(SATIN_STEP);

  // Only (r*step) mod 8 matters, so a 3-bit product is exact.
  logic [2:0] satin_shift;
  assign satin_shift = 3'(r_i[2:0] * STEP3);

  always_comb begin
    row_o = 8'h00;
    unique case (mode_i)
      MODE_PLAIN: row_o = r_i[0] ? 8'hAA : 8'h55;
      MODE_TWILL: row_o = rotl8(base_i, r_i[2:0]);
      MODE_SATIN: row_o = rotl8(base_i, satin_shift);
      MODE_USER:  row_o = base_i ^ r_i;
      default:    row_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/weave_row_tx.sv
// weave_row_tx: emits a burst of weave row bytes over a valid/ready stream.
//   clk, rst            - clock, synchronous active-high reset
//   start               - request a burst (honoured in IDLE only)
//   mode, base, count   - burst parameters, captured on accepted start
//                         (count 0 = 256 rows)
//   tx_data/tx_valid/tx_ready/tx_last - registered row stream
//   busy                - burst in progress (SEND or FINISH)
//   done                - one-cycle pulse after the final row handshake
//
// state  | meaning
// IDLE   | waiting for start
// SEND   | presenting rows, advancing on each handshake
// FINISH | one-cycle done pulse, then back to IDLE
module weave_row_tx
  import weave_pkg::*;
#(
  parameter int unsigned SATIN_STEP  = 3,
  parameter int unsigned LATENCY_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] base,
  input  logic [7:0] count,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       busy,
  output logic       done
);

  if (LATENCY_REG != 1) begin : g_latency_check
    $error("weave_row_tx: only LATENCY_REG = 1 is implemented");
  end

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [7:0] base_q, base_d;
  logic [7:0] count_q, count_d;
  logic [7:0] r_q, r_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  mode_e      gen_mode;
  logic [7:0] gen_base;
  logic [7:0] gen_r;
  logic [7:0] gen_row;
  logic [7:0] r_inc;
  logic [7:0] cnt_m1;

  assign r_inc  = r_q + 8'd1;
  assign cnt_m1 = count_q - 8'd1;

  // One generator is shared: in IDLE it sees the incoming parameters at
  // r=0 so row 0 is ready the cycle SEND starts; in SEND it looks one row
  // ahead so the next row is loaded on the handshake edge.
  weave_row_gen #(
    .SATIN_STEP (SATIN_STEP)
  ) u_row_gen (
    .mode_i (gen_mode),
    .base_i (gen_base),
    .r_i    (gen_r),
    .row_o  (gen_row)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    count_d  = count_q;
    r_d      = r_q;
    data_d   = data_q;
    last_d   = last_q;
    gen_mode = mode_q;
    gen_base = base_q;
    gen_r    = r_inc;

    unique case (state_q)
      IDLE: begin
        gen_mode = mode_e'(mode);
        gen_base = base;
        gen_r    = 8'd0;
        if (start) begin
          state_d = SEND;
          mode_d  = mode_e'(mode);
          base_d  = base;
          count_d = count;
          r_d     = 8'd0;
          data_d  = gen_row;
          last_d  = (count == 8'd1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          r_d = r_inc;
          if (last_q) begin
            state_d = FINISH;
            last_d  = 1'b0;
          end else begin
            data_d = gen_row;
            last_d = (r_inc == cnt_m1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_PLAIN;
      base_q  <= 8'h00;
      count_q <= 8'h00;
      r_q     <= 8'h00;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      count_q <= count_d;
      r_q     <= r_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_last  = last_q;
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_weave_row_tx.sv
module tb_weave_row_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] base;
  logic [7:0] count;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  weave_row_tx #(.SATIN_STEP(3), .LATENCY_REG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .base     (base),
    .count    (count),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      base;
    logic [7:0]      count;
    logic [3:0][7:0] rows;  // rows[i] = expected row i
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [7:0] d, input logic l);
    check({name, " valid"}, 32'(tx_valid), 32'd1);
    check({name, " data"},  32'(tx_data),  32'(d));
    check({name, " last"},  32'(tx_last),  32'(l));
    check({name, " busy"},  32'(busy),     32'd1);
    check({name, " done"},  32'(done),     32'd0);
  endtask

  task automatic check_finish(input string name);
    check({name, " fin valid"}, 32'(tx_valid), 32'd0);
    check({name, " fin done"},  32'(done),     32'd1);
    check({name, " fin busy"},  32'(busy),     32'd1);
    tick();
    check({name, " idle done"}, 32'(done), 32'd0);
    check({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] b, input logic [7:0] c);
    mode = m; base = b; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mode: 2'b01, base: 8'h0F, count: 8'd3, rows: {8'h00, 8'h3C, 8'h1E, 8'h0F}};
    vecs[1] = '{mode: 2'b10, base: 8'h01, count: 8'd4, rows: {8'h02, 8'h40, 8'h08, 8'h01}};
    vecs[2] = '{mode: 2'b00, base: 8'h33, count: 8'd3, rows: {8'h00, 8'h55, 8'hAA, 8'h55}};
    vecs[3] = '{mode: 2'b11, base: 8'hA5, count: 8'd4, rows: {8'hA6, 8'hA7, 8'hA4, 8'hA5}};
    vecs[4] = '{mode: 2'b01, base: 8'h81, count: 8'd1, rows: {8'h00, 8'h00, 8'h00, 8'h81}};
    vecs[5] = '{mode: 2'b10, base: 8'h80, count: 8'd2, rows: {8'h00, 8'h00, 8'h04, 8'h80}};

    rst = 1'b1; start = 1'b0; mode = 2'b00; base = 8'h00; count = 8'h00; tx_ready = 1'b0;
    tick(); tick();
    check("rst valid", 32'(tx_valid), 32'd0);
    check("rst last",  32'(tx_last),  32'd0);
    check("rst busy",  32'(busy),     32'd0);
    check("rst done",  32'(done),     32'd0);
    check("rst data",  32'(tx_data),  32'h00);
    rst = 1'b0;
    tick();

    // table bursts, consumer always ready
    tx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].mode, vecs[v].base, vecs[v].count);
      for (int i = 0; i < int'(vecs[v].count); i++) begin
        check_row($sformatf("vec%0d row%0d", v, i), vecs[v].rows[i], i == int'(vecs[v].count) - 1);
        tick();
      end
      check_finish($sformatf("vec%0d", v));
    end

    // backpressure: row 0 held for 4 cycles
    tx_ready = 1'b0;
    do_start(2'b00, 8'hFF, 8'd2);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) tx_ready = 1'b1;
      check_row($sformatf("bp hold%0d", k), 8'h55, 1'b0);
      tick();
    end
    check_row("bp row1", 8'hAA, 1'b1);
    tick();
    check_finish("bp");

    // count=0 -> 256 rows, user mode base 0
    do_start(2'b11, 8'h00, 8'd0);
    for (int i = 0; i < 256; i++) begin
      if (tx_data !== 8'(i) || tx_last !== (i == 255) || busy !== 1'b1 || tx_valid !== 1'b1)
        check($sformatf("c256 row%0d", i), {22'd0, tx_valid, busy, tx_last, tx_data},
              {22'd0, 1'b1, 1'b1, 1'(i == 255), 8'(i)});
      else
        total++;
      tick();
    end
    check_finish("c256");

    // start while busy is ignored
    do_start(2'b01, 8'h0F, 8'd3);
    check_row("sb row0", 8'h0F, 1'b0);
    tick();
    mode = 2'b11; base = 8'h77; count = 8'd9; start = 1'b1;
    check_row("sb row1", 8'h1E, 1'b0);
    tick();
    start = 1'b0;
    check_row("sb row2", 8'h3C, 1'b1);
    tick();
    check_finish("sb");
    tick();
    check("sb no rerun valid", 32'(tx_valid), 32'd0);
    check("sb no rerun done",  32'(done),     32'd0);

    // reset mid-burst, with start and handshake also active
    do_start(2'b11, 8'h10, 8'd5);
    check_row("rm row0", 8'h10, 1'b0);
    tick();
    check_row("rm row1", 8'h11, 1'b0);
    tick();
    check_row("rm row2", 8'h12, 1'b0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rm valid", 32'(tx_valid), 32'd0);
    check("rm busy",  32'(busy),     32'd0);
    check("rm done",  32'(done),     32'd0);
    check("rm data",  32'(tx_data),  32'h00);
    tick();
    check("rm no done", 32'(done), 32'd0);
    check("rm idle",    32'(busy), 32'd0);
    do_start(2'b11, 8'h10, 8'd2);
    check_row("rm2 row0", 8'h10, 1'b0);
    tick();
    check_row("rm2 row1", 8'h11, 1'b1);
    tick();
    check_finish("rm2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weave_row_tx.md
WEAVE_ROW_TX -- requirements
Module: weave_row_tx

Interface
REQ-001 SHALL have parameter SATIN_STEP, default 3, rotate step per row in satin mode (1..7, odd).
REQ-002 SHALL have parameter LATENCY_REG, default 1, 1 = data/valid driven from registers, 0 is not supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a pattern burst.
REQ-006 SHALL have port mode  input  2  pattern select, sampled on accepted start: 00 plain, 01 twill, 10 satin, 11 user.
REQ-007 SHALL have port base  input  8  seed row byte, sampled on accepted start.
REQ-008 SHALL have port count  input  8  rows per burst, sampled on accepted start; 0 means 256.
REQ-009 SHALL have port tx_data  output  8  current row byte (1 = warp up).
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid row.
REQ-011 SHALL have port tx_ready  input  1  consumer accepts the current row.
REQ-012 SHALL have port tx_last  output  1  current row is the final row of the burst.
REQ-013 SHALL have port busy  output  1  burst in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final row handshake.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, FINISH; IDLE on reset.
REQ-016 SHALL accept start only in IDLE; start in SEND or FINISH ignored, no side effects.
REQ-017 SHALL, on accepted start, latch mode/base/count, clear row index r to 0, enter SEND with tx_valid=1 on the next cycle.
REQ-018 SHALL compute row byte: plain = 0x55 if r even else 0xAA (base ignored); twill = base rotated left by (r mod 8); satin = base rotated left by ((r*SATIN_STEP) mod 8); user = base XOR r[7:0].
REQ-019 SHALL treat a handshake as tx_valid & tx_ready on a rising edge; r increments by 1 per handshake, 8-bit, wraps 255->0.
REQ-020 SHALL hold tx_data, tx_last, tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-021 SHALL assert tx_last exactly during the row with index count-1 (index 255 when count=0).
REQ-022 SHALL, on handshake with tx_last=1, deassert tx_valid next cycle and enter FINISH.
REQ-023 SHALL assert done for exactly the one cycle in FINISH, then return to IDLE; start is accepted again on the cycle after FINISH.
REQ-024 SHALL drive busy=1 in SEND and FINISH, 0 in IDLE.
REQ-025 SHALL produce back-to-back rows (one per cycle) when tx_ready is held high; no bubble between rows.
REQ-026 SHALL never drive tx_valid=1 in IDLE or FINISH.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, force IDLE, tx_valid=0, tx_last=0, busy=0, done=0, tx_data=0x00, r=0, latched mode/base/count=0.
REQ-028 SHALL, on reset mid-burst, abandon the burst with no done pulse; rst has priority over start and handshake in the same cycle.

Structure
REQ-029 SHALL place mode encoding enum (MODE_PLAIN, MODE_TWILL, MODE_SATIN, MODE_USER) and FSM state enum in shared package weave_pkg.
REQ-030 SHALL implement the row-byte function as combinational sub-module weave_row_gen (inputs mode, base, r; output row byte), reusable by the matching receiver-side checker.
REQ-031 SHALL register tx_data from weave_row_gen output; no combinational path from tx_ready to tx_data.

Verification
REQ-032 SHALL cover twill: mode=01, base=0x0F, count=3, tx_ready=1 -> tx_data 0x0F, 0x1E, 0x3C on consecutive cycles, tx_last on 0x3C, done one cycle later.
REQ-033 SHALL cover satin: mode=10, base=0x01, count=4, SATIN_STEP=3 -> 0x01, 0x08, 0x40, 0x02.
REQ-034 SHALL cover backpressure: mode=00, count=2, tx_ready low 3 cycles at row 0 -> 0x55 held stable 4 cycles, then 0xAA with tx_last.
REQ-035 SHALL cover count=0: mode=11, base=0x00 -> 256 rows 0x00..0xFF, tx_last only on 0xFF, busy high throughout.
REQ-036 SHALL cover start while busy: second start during row 1 of count=3 -> ignored, exactly 3 rows and one done.
REQ-037 SHALL cover reset mid-burst: rst at row 2 of count=5 -> tx_valid=0, busy=0 next cycle, no done; fresh start then runs normally from r=0.
